// File: rtl/cva6_proc_shim_pkg.sv
// cva6_proc_shim_pkg: shared opcodes, funct3 codes, LSU state and store-buffer entry type
package cva6_proc_shim_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_WORD = 3'd2;
  typedef enum logic {IDLE, LOAD_WAIT} lsu_state_e;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } sb_entry_t;
endpackage

// File: rtl/cva6_proc_shim_sbuf.sv
// cva6_proc_shim_sbuf: circular store buffer with youngest-match forwarding lookup
module cva6_proc_shim_sbuf
  import cva6_proc_shim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [4:0]  lookup_idx,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty,
  output logic        hit,
  output logic [31:0] hit_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, slot;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = q[rd_ptr];

  // Ring pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (push) q[wr_ptr] <= push_entry;
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Walk oldest to youngest so the last live match (the youngest) wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && q[slot].idx == lookup_idx) begin
        hit      = 1'b1;
        hit_data = q[slot].data;
      end
      slot = inc(slot);
    end
  end
endmodule

// File: rtl/cva6_proc_shim.sv
// cva6_proc_shim: in-order RV32I ALU/LW/SW shim with store buffer and data-independent ready
module cva6_proc_shim
  import cva6_proc_shim_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        store_mem_resp_i,
  input  logic        load_mem_resp_i
`ifdef EXPOSE_STATE
  ,
  output logic [1023:0] regfile_o,
  output logic [1023:0] mem_o
`endif
);
  logic [31:0] regs [32];
  logic [31:0] mem  [32];
  lsu_state_e  state;
  logic [4:0]  ld_rd, ld_idx;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2, idx;
  logic [31:0] a, b, imm_i, y, alu, hit_data;
  logic [6:0]  imm_s;
  logic        fire, alt, is_alu, is_sw, is_lw, drain, full, empty, hit;
  sb_entry_t   head;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {instr_i[26:25], instr_i[11:7]};
  assign a      = regs[rs1];
  assign b      = regs[rs2];
  assign y      = opcode == OP ? b : imm_i;
  assign alt    = instr_i[30] & (opcode == OP | f3 == F3_SR);
  assign idx    = 5'((a[6:0] + (opcode == STORE ? imm_s : imm_i[6:0])) >> 2);

  assign instr_ready_o = state == IDLE & !full;
  assign fire   = instr_valid_i & instr_ready_o;
  assign is_alu = fire & (opcode == OP_IMM | opcode == OP);
  assign is_sw  = fire & opcode == STORE & f3 == F3_WORD;
  assign is_lw  = fire & opcode == LOAD & f3 == F3_WORD;
  assign drain  = !empty & store_mem_resp_i;

  // Integer ALU shared by OP and OP-IMM; alt selects SUB/SRA/SRAI
  always_comb begin
    case (f3)
      F3_ADD:  alu = alt ? a - y : a + y;
      F3_SLL:  alu = a << y[4:0];
      F3_SLT:  alu = {31'b0, $signed(a) < $signed(y)};
      F3_SLTU: alu = {31'b0, a < y};
      F3_XOR:  alu = a ^ y;
      F3_SR:   alu = alt ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
      F3_OR:   alu = a | y;
      default: alu = a & y;
    endcase
  end

  cva6_proc_shim_sbuf #(.DEPTH(SB_DEPTH)) u_sbuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (is_sw),
    .push_entry ('{idx: idx, data: b}),
    .pop        (drain),
    .lookup_idx (ld_idx),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // Register file: ALU results at acceptance, load data at completion; x0 is never written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (is_alu && rd != '0) regs[rd] <= alu;
      if (state == LOAD_WAIT && load_mem_resp_i && ld_rd != '0) regs[ld_rd] <= hit ? hit_data : mem[ld_idx];
    end
  end

  // Data memory updated only by the oldest store-buffer entry as it drains
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (drain) begin
      mem[head.idx] <= head.data;
    end
  end

  // LSU FSM: a word load holds issue until the memory response arrives
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ld_rd  <= '0;
      ld_idx <= '0;
    end else if (is_lw) begin
      state  <= LOAD_WAIT;
      ld_rd  <= rd;
      ld_idx <= idx;
    end else if (state == LOAD_WAIT && load_mem_resp_i) begin
      state <= IDLE;
    end
  end

`ifdef EXPOSE_STATE
  for (genvar g = 0; g < 32; g++) begin : g_expose
    assign regfile_o[32*g +: 32] = regs[g];
    assign mem_o[32*g +: 32]     = mem[g];
  end
`endif
endmodule

// File: tb/tb_cva6_proc_shim.sv
// tb_cva6_proc_shim: directed plus random checks against a queue-based ISA/LSU model
module tb_cva6_proc_shim;
  localparam int SB_DEPTH = 4;

  logic        clk = 0, rst_n = 1, valid = 0, sresp = 0, lresp = 0, ready_a, ready_b, last_ready;
  logic [31:0] instr = '0, instr_b;
  logic [11:0] noise = '0;
  int          checks = 0, errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [32];
  logic [36:0] m_q [$];
  bit          m_loading;
  logic [4:0]  m_rd, m_idx;

  assign instr_b = {noise, instr[19:0]};

`ifdef EXPOSE_STATE
  logic [1023:0] rf_a, mm_a, rf_b, mm_b;
`endif

  cva6_proc_shim #(.SB_DEPTH(SB_DEPTH)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(valid), .instr_ready_o(ready_a),
    .store_mem_resp_i(sresp), .load_mem_resp_i(lresp)
`ifdef EXPOSE_STATE
    , .regfile_o(rf_a), .mem_o(mm_a)
`endif
  );

  cva6_proc_shim #(.SB_DEPTH(SB_DEPTH)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr_b), .instr_valid_i(valid), .instr_ready_o(ready_b),
    .store_mem_resp_i(sresp), .load_mem_resp_i(lresp)
`ifdef EXPOSE_STATE
    , .regfile_o(rf_b), .mem_o(mm_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] y, input bit alt);
    int sh;
    sh = int'(y[4:0]);
    case (f3)
      0: return alt ? a - y : a + y;
      1: return a << sh;
      2: return ($signed(a) < $signed(y)) ? 1 : 0;
      3: return (a < y) ? 1 : 0;
      4: return a ^ y;
      5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      6: return a | y;
      default: return a & y;
    endcase
  endfunction

  function automatic bit m_ready();
    return !m_loading && m_q.size() < SB_DEPTH;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_mem[i]  = '0;
    end
    m_q.delete();
    m_loading = 0;
    m_rd = '0;
    m_idx = '0;
  endtask

  // One clock edge of the architectural model: drain, then load completion, then the accepted instruction
  task automatic m_edge(input logic [31:0] i, input logic v, input logic s, input logic l);
    bit          acc;
    logic [36:0] e;
    logic [31:0] d, ra, rb, immi, imms, addr;
    logic [4:0]  rd;
    logic [2:0]  f3;
    acc = v && m_ready();
    if (m_q.size() > 0 && s) begin
      e = m_q.pop_front();
      m_mem[e[36:32]] = e[31:0];
    end
    if (m_loading && l) begin
      d = m_mem[m_idx];
      foreach (m_q[k]) if (m_q[k][36:32] == m_idx) d = m_q[k][31:0];
      if (m_rd != 0) m_regs[m_rd] = d;
      m_loading = 0;
    end
    if (acc) begin
      rd   = i[11:7];
      f3   = i[14:12];
      ra   = m_regs[i[19:15]];
      rb   = m_regs[i[24:20]];
      immi = {{20{i[31]}}, i[31:20]};
      imms = {{20{i[31]}}, i[31:25], i[11:7]};
      case (i[6:0])
        7'h13: if (rd != 0) m_regs[rd] = ref_alu(f3, ra, immi, f3 == 5 && i[30]);
        7'h33: if (rd != 0) m_regs[rd] = ref_alu(f3, ra, rb, i[30]);
        7'h03: if (f3 == 2) begin
          addr = ra + immi;
          m_loading = 1;
          m_rd = rd;
          m_idx = addr[6:2];
        end
        7'h23: if (f3 == 2) begin
          addr = ra + imms;
          m_q.push_back({addr[6:2], rb});
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic [31:0] i, input logic v, input logic s, input logic l);
    instr = i;
    valid = v;
    sresp = s;
    lresp = l;
    @(negedge clk);
    last_ready = ready_a;
    check("ready", ready_a, m_ready());
    check("ready_indep", ready_a, ready_b);
    m_edge(i, v, s, l);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_x%0d", tag, i), dut_a.regs[i], m_regs[i]);
      check($sformatf("%s_mem%0d", tag, i), dut_a.mem[i], m_mem[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    valid = 0;
    sresp = 0;
    lresp = 0;
    m_clear();
    #2;
    check("rst_ready", ready_a, 1);
    compare_state("rst");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] wf3;
    wf3 = ($urandom_range(0, 3) != 0) ? 3'd2 : 3'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: return enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)), 7'h13);
      3, 4:    return enc_r($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)));
      5, 6:    return enc_s(12'($urandom_range(0, 255)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), wf3);
      7, 8:    return enc_i(12'($urandom_range(0, 255)), 5'($urandom_range(0, 7)), wf3, 5'($urandom_range(0, 7)), 7'h03);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int zeros;
    #3;
    do_reset();

    // ALU then store/load, forwarding from the undrained buffer
    cyc(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 1, 0, 1);
    cyc(enc_s(12'd0, 5'd1, 5'd2, 3'd2), 1, 0, 1);
    cyc(enc_i(12'd0, 5'd2, 3'd2, 5'd3, 7'h03), 1, 0, 1);
    cyc('0, 0, 0, 1);
    check("fwd_x3", dut_a.regs[3], 32'd5);
    check("fwd_mem0", dut_a.mem[0], 32'd0);
    check("fwd_ready_after", ready_a, 1);

    // Same program with drain enabled
    do_reset();
    cyc(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 1, 1, 1);
    cyc(enc_s(12'd0, 5'd1, 5'd2, 3'd2), 1, 1, 1);
    check("drain_mem0_at_push", dut_a.mem[0], 32'd0);
    cyc(enc_i(12'd0, 5'd2, 3'd2, 5'd3, 7'h03), 1, 1, 1);
    check("drain_mem0", dut_a.mem[0], 32'd5);
    cyc('0, 0, 1, 1);
    check("drain_x3", dut_a.regs[3], 32'd5);

    // Load stall: response low for three cycles
    do_reset();
    cyc(enc_i(12'd1, 5'd0, 3'd0, 5'd4, 7'h13), 1, 0, 0);
    cyc(enc_i(12'd0, 5'd0, 3'd2, 5'd4, 7'h03), 1, 0, 0);
    zeros = 0;
    for (int k = 0; k < 3; k++) begin
      cyc('0, 0, 0, 0);
      zeros += last_ready ? 0 : 1;
    end
    check("stall_x4_pending", dut_a.regs[4], 32'd1);
    cyc('0, 0, 0, 1);
    zeros += last_ready ? 0 : 1;
    check("stall_x4_done", dut_a.regs[4], 32'd0);
    cyc('0, 0, 0, 0);
    check("stall_cycles", 32'(zeros), 32'd4);
    check("stall_ready_after", last_ready, 1);

    // Buffer full with no drain, then one drain re-raises ready
    do_reset();
    cyc(enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'h13), 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(enc_s(12'(4 * k), 5'd1, 5'd0, 3'd2), 1, 0, 0);
    check("full_ready_5th", last_ready, 0);
    cyc('0, 0, 1, 0);
    check("full_ready_reraised", ready_a, 1);
    check("full_mem0", dut_a.mem[0], 32'd3);

    // x0 writes dropped, unknown opcode is a NOP
    do_reset();
    cyc(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 1, 0, 0);
    check("x0_zero", dut_a.regs[0], 32'd0);
    cyc(enc_i(12'd11, 5'd0, 3'd0, 5'd5, 7'h13), 1, 0, 0);
    cyc(enc_i(12'd99, 5'd5, 3'd0, 5'd5, 7'h7f), 1, 0, 0);
    check("nop_x5", dut_a.regs[5], 32'd11);
    check("nop_ready", ready_a, 1);

    // Reset asserted while a load is outstanding
    cyc(enc_s(12'd8, 5'd5, 5'd0, 3'd2), 1, 0, 0);
    cyc(enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'h03), 1, 0, 0);
    check("midload_ready_low", ready_a, 0);
    do_reset();
    cyc('0, 0, 0, 1);

    // Randomized run; the second instance sees different immediates
    for (int n = 0; n < 3000; n++) begin
      noise = 12'($urandom);
      cyc(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      if (n % 500 == 499) compare_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cva6_proc_shim.md
# cva6_proc_shim

Compact in-order RV32I execution shim modelling the CVA6 issue and load/store-unit handshake. It accepts one instruction per valid/ready handshake and executes integer register/immediate ALU ops, LW and SW against a 32-entry register file and a 32-word data memory. Stores pass through a store buffer; loads wait for a memory response. It sits under the LSU non-interference harness: `instr_ready_o` timing must depend only on the instruction stream and memory responses, never on data values.

## Interface
- `SB_DEPTH`, default 4: store-buffer entries, minimum 1.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `instr_i`  in  32: RV32I instruction word.
- `instr_valid_i`  in  1: `instr_i` is valid.
- `instr_ready_o`  out  1: shim can accept an instruction. Acceptance occurs when `instr_valid_i & instr_ready_o`.
- `store_mem_resp_i`  in  1: memory accepts the oldest store-buffer entry.
- `load_mem_resp_i`  in  1: memory returns the pending load.
- `regfile_o`  out  1024: register i at bits [32i+31:32i]. Present only when `EXPOSE_STATE` is defined.
- `mem_o`  out  1024: memory word i at bits [32i+31:32i]. Present only when `EXPOSE_STATE` is defined.

## Operation
- **Reset state.** Registers, memory and store buffer are cleared. LSU is in IDLE. `instr_ready_o` = 1.
- **x0.** Reads return 0 and writes to x0 are dropped.
- **OP-IMM (0010011).**
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Immediate is sign-extended. Shift amount is imm[4:0].
- **OP (0110011).** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- **Other opcodes.** Any other opcode or funct3 is a NOP, and ready is unaffected.
- **Address rule.** Effective address = rs1 + sext(imm), wrapping at 32 bits. The word index is addr[6:2], and addr[1:0] is ignored.
- **SW (0100011, funct3 010).** Pushes {index, rs2 value} into the store buffer. Memory is written only when the entry drains.
- **Store drain.** When the buffer is non-empty and `store_mem_resp_i` = 1, the oldest entry is written to memory and popped.
- **LW (0000011, funct3 010).**
  - Latches rd and the index, then enters LOAD_WAIT.
  - Load data is the youngest matching store-buffer entry, else the memory word.
  - Data is sampled in the completion cycle, after that cycle's drain.
- **Other load/store widths.** Any other width is a NOP.
- **LSU FSM.**
  - IDLE → LOAD_WAIT on LW acceptance.
  - LOAD_WAIT → IDLE in any cycle with `load_mem_resp_i` = 1. rd is written at that edge.
- **Ready.** `instr_ready_o` = (state == IDLE) & !(buffer full).
- **Data independence.** Ready never depends on register or memory contents.

## Timing
- **ALU ops.** Execute combinationally on acceptance. rd is written at the accepting edge. The next instruction can be accepted the next cycle, so no hazards exist.
- **LW accepted at edge t.**
  - Ready is 0 from t until the completion edge, then 1.
  - With `load_mem_resp_i` tied high, ready is low for exactly one cycle.
- **SW.** Ready stays high unless the push makes the buffer full.
- **Same-cycle drain and push.** Count is unchanged and ready is computed from the count before the push.
- **Drain while LOAD_WAIT.** Proceeds normally.
- **Full buffer with no `store_mem_resp_i`.** Ready stays 0 indefinitely. This is permitted behaviour.
- **Reset assertion mid-load.** Returns immediately to the reset state. The pending load is discarded.

## Structure
- **Shared package `cva6_proc_shim_pkg`:**
  - opcode constants: OP_IMM, OP, LOAD, STORE;
  - funct3 constants;
  - LSU state enum {IDLE, LOAD_WAIT};
  - store-buffer entry struct {idx[4:0], data[31:0]}.
- **Sub-module `cva6_proc_shim_sbuf`:** circular store buffer providing push, pop, full/empty, and a youngest-match forward lookup.
- **Top level:** decode, ALU, regfile and memory arrays.

## Test plan
- **ALU then store/load.** Reset, then ADDI x1,x0,5; SW x1,0(x2); LW x3,0(x2) with load_resp=1 and store_resp=0.
  - x3 = 5 via forwarding.
  - mem_o word 0 is still 0.
- **Drain.** Same program with store_resp=1.
  - Word 0 = 5 the cycle after the SW.
- **Load stall.** LW with load_resp low for 3 cycles then high.
  - Ready is 0 for 4 cycles, then 1; rd is written at the response edge.
- **Buffer full.** Five SWs with store_resp=0 and SB_DEPTH=4.
  - Ready drops after the 4th SW; asserting one store_resp re-raises ready.
- **Data independence.** Two instances run the same program with different immediates.
  - `instr_ready_o` traces are identical every cycle.
- **Misc.**
  - ADDI x0,x0,7 leaves x0 = 0.
  - An unknown opcode is a NOP.
  - Reset during LOAD_WAIT gives ready = 1 and all state 0.
